// File: rtl/burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : burst_scheduler
// Summary  : System time keeper with 1PPS preset plus a DEPTH-deep queue of
//            burst descriptors, played back as TX/BL1/RX/BL2 period trains
//            that drive the En_Iz/En_Pr gates and DDS start strobes.
// Revision : 1.0 - initial release
// ============================================================================
module burst_scheduler #(
  parameter int TW    = 64,
  parameter int CW    = 32,
  parameter int NW    = 16,
  parameter int FW    = 48,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [TW-1:0]            SYS_TIME,
  input  logic                     SYS_TIME_UPDATE,
  input  logic                     T1hz,
  output logic                     SYS_TIME_UPDATE_OK,
  output logic [TW-1:0]            TIME_NOW,
  input  logic                     WR_DATA,
  input  logic [FW-1:0]            MEM_DDS_freq,
  input  logic [TW-1:0]            MEM_TIME_START,
  input  logic [NW-1:0]            MEM_N_impuls,
  input  logic [1:0]               MEM_TYPE_impulse,
  input  logic [CW-1:0]            MEM_Interval_Ti,
  input  logic [CW-1:0]            MEM_Interval_Tp,
  input  logic [CW-1:0]            MEM_Tblank1,
  input  logic [CW-1:0]            MEM_Tblank2,
  input  logic                     ABORT,
  input  logic                     ERR_CLR,
  output logic [FW-1:0]            DDS_freq,
  output logic                     DDS_start,
  output logic                     En_Iz,
  output logic                     En_Pr,
  output logic                     BUSY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     FULL,
  output logic                     OVF,
  output logic                     LATE
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full_level = (c_aw + 1)'(DEPTH);

  // Only the coherent/incoherent distinction of the type field matters,
  // so it is stored as a single flag.
  typedef struct packed {
    logic [FW-1:0] freq;
    logic [TW-1:0] start;
    logic [NW-1:0] n;
    logic          coherent;
    logic [CW-1:0] ti;
    logic [CW-1:0] tb1;
    logic [CW-1:0] tp;
    logic [CW-1:0] tb2;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_TX   = 3'd2,
    S_BL1  = 3'd3,
    S_RX   = 3'd4,
    S_BL2  = 3'd5
  } state_t;

  // ---------------------------------------------------------------- time base
  logic [TW-1:0] r_time;
  logic          r_t1hz_d;
  logic          r_t1hz_rise;
  logic          r_upd_d;
  logic          r_ok;

  // Free-running time with a preset taken two edges after T1hz rises.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_time      <= '0;
      r_t1hz_d    <= 1'b0;
      r_t1hz_rise <= 1'b0;
      r_upd_d     <= 1'b0;
      r_ok        <= 1'b0;
    end else begin
      r_t1hz_d    <= T1hz;
      r_t1hz_rise <= T1hz & ~r_t1hz_d;
      r_upd_d     <= SYS_TIME_UPDATE;
      if (r_t1hz_rise && SYS_TIME_UPDATE && !r_ok) begin
        r_time <= SYS_TIME;
        r_ok   <= 1'b1;
      end else begin
        r_time <= r_time + TW'(1);
        if (SYS_TIME_UPDATE && !r_upd_d) begin
          r_ok <= 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------- queue
  desc_t         r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_level;
  desc_t         w_wr_desc;
  desc_t         w_head;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_head_zero;
  logic          w_head_late;
  logic          w_accept;
  state_t        r_state;

  assign w_wr_desc = '{freq:     MEM_DDS_freq,
                       start:    MEM_TIME_START,
                       n:        MEM_N_impuls,
                       coherent: (MEM_TYPE_impulse == 2'd1),
                       ti:       MEM_Interval_Ti,
                       tb1:      MEM_Tblank1,
                       tp:       MEM_Interval_Tp,
                       tb2:      MEM_Tblank2};

  assign w_full      = (r_level == c_full_level);
  assign w_push      = WR_DATA & ~w_full & ~ABORT;
  assign w_pop       = (r_state == S_IDLE) & (r_level != '0) & ~ABORT;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_zero = (w_head.n == '0);
  assign w_head_late = (w_head.start < r_time);
  assign w_accept    = w_pop & ~w_head_zero & ~w_head_late;

  // Descriptor storage; contents are only meaningful below the level count.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_desc;
    end
  end

  // Queue pointers and occupancy; ABORT empties the queue outright.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (ABORT) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (c_aw + 1)'(1);
        2'b01:   r_level <= r_level - (c_aw + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky errors; a new error in the same cycle beats ERR_CLR.
  logic r_ovf;
  logic r_late;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ovf  <= 1'b0;
      r_late <= 1'b0;
    end else begin
      if (WR_DATA && w_full && !ABORT) r_ovf <= 1'b1;
      else if (ERR_CLR)                r_ovf <= 1'b0;
      if (w_pop && !w_head_zero && w_head_late) r_late <= 1'b1;
      else if (ERR_CLR)                         r_late <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- playback
  desc_t         r_cur;
  logic [CW-1:0] r_phase_cnt;
  logic [NW-1:0] r_pulse_cnt;
  logic          r_dds_start;
  logic [CW-1:0] w_len [4];
  logic [1:0]    w_cur_idx;
  logic [1:0]    w_first_idx;
  logic [1:0]    w_next_idx;
  logic          w_any;
  logic          w_has_next;

  assign w_len[0] = r_cur.ti;
  assign w_len[1] = r_cur.tb1;
  assign w_len[2] = r_cur.tp;
  assign w_len[3] = r_cur.tb2;

  function automatic state_t phase_state(input logic [1:0] idx);
    case (idx)
      2'd0:    return S_TX;
      2'd1:    return S_BL1;
      2'd2:    return S_RX;
      default: return S_BL2;
    endcase
  endfunction

  // Locate the first non-empty phase of a period and the next non-empty
  // phase after the current one, so zero-length phases cost no cycles.
  always_comb begin
    case (r_state)
      S_BL1:   w_cur_idx = 2'd1;
      S_RX:    w_cur_idx = 2'd2;
      S_BL2:   w_cur_idx = 2'd3;
      default: w_cur_idx = 2'd0;
    endcase
    w_any       = 1'b0;
    w_first_idx = 2'd0;
    w_has_next  = 1'b0;
    w_next_idx  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_len[i] != '0) begin
        w_any       = 1'b1;
        w_first_idx = 2'(i);
        if (i > int'(w_cur_idx)) begin
          w_has_next = 1'b1;
          w_next_idx = 2'(i);
        end
      end
    end
  end

  state_t        w_state_nxt;
  logic [CW-1:0] w_phase_nxt;
  logic [NW-1:0] w_pulse_nxt;
  logic          w_goto;
  logic [1:0]    w_goto_idx;
  logic          w_first_tx;
  logic          w_enter_tx;

  // Next-state logic: wait for the start time, then walk the phases.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase_cnt;
    w_pulse_nxt = r_pulse_cnt;
    w_goto      = 1'b0;
    w_goto_idx  = 2'd0;
    w_first_tx  = 1'b0;
    w_enter_tx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_time >= r_cur.start) begin
          w_pulse_nxt = NW'(1);
          w_first_tx  = 1'b1;
          if (w_any) begin
            w_goto     = 1'b1;
            w_goto_idx = w_first_idx;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_TX, S_BL1, S_RX, S_BL2: begin
        if (r_phase_cnt > CW'(1)) begin
          w_phase_nxt = r_phase_cnt - CW'(1);
        end else if (w_has_next) begin
          w_goto     = 1'b1;
          w_goto_idx = w_next_idx;
        end else if (r_pulse_cnt < r_cur.n) begin
          w_pulse_nxt = r_pulse_cnt + NW'(1);
          w_goto      = 1'b1;
          w_goto_idx  = w_first_idx;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_goto) begin
      w_state_nxt = phase_state(w_goto_idx);
      w_phase_nxt = w_len[w_goto_idx];
      w_enter_tx  = (w_goto_idx == 2'd0);
    end
    if (ABORT) begin
      w_state_nxt = S_IDLE;
      w_enter_tx  = 1'b0;
    end
  end

  // FSM state, phase/pulse counters and the DDS strobe.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= '0;
      r_pulse_cnt <= '0;
      r_dds_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase_cnt <= w_phase_nxt;
      r_pulse_cnt <= w_pulse_nxt;
      r_dds_start <= w_enter_tx & (~r_cur.coherent | w_first_tx);
    end
  end

  // Active descriptor, captured when a popped head is accepted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cur <= '0;
    end else if (w_accept) begin
      r_cur <= w_head;
    end
  end

  assign SYS_TIME_UPDATE_OK = r_ok;
  assign TIME_NOW           = r_time;
  assign DDS_freq           = r_cur.freq;
  assign DDS_start          = r_dds_start;
  assign En_Iz              = (r_state == S_TX);
  assign En_Pr              = (r_state == S_RX);
  assign BUSY               = (r_state != S_IDLE);
  assign LEVEL              = r_level;
  assign FULL               = w_full;
  assign OVF                = r_ovf;
  assign LATE               = r_late;

endmodule
`default_nettype wire

// File: tb/tb_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_scheduler
// Summary  : Directed self-checking bench for burst_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_scheduler;

  localparam int TW = 64, CW = 32, NW = 16, FW = 48, DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [TW-1:0] SYS_TIME = '0;
  logic          SYS_TIME_UPDATE = 1'b0;
  logic          T1hz = 1'b0;
  logic          SYS_TIME_UPDATE_OK;
  logic [TW-1:0] TIME_NOW;
  logic          WR_DATA = 1'b0;
  logic [FW-1:0] MEM_DDS_freq = '0;
  logic [TW-1:0] MEM_TIME_START = '0;
  logic [NW-1:0] MEM_N_impuls = '0;
  logic [1:0]    MEM_TYPE_impulse = '0;
  logic [CW-1:0] MEM_Interval_Ti = '0, MEM_Interval_Tp = '0;
  logic [CW-1:0] MEM_Tblank1 = '0, MEM_Tblank2 = '0;
  logic          ABORT = 1'b0;
  logic          ERR_CLR = 1'b0;
  logic [FW-1:0] DDS_freq;
  logic          DDS_start, En_Iz, En_Pr, BUSY, FULL, OVF, LATE;
  logic [$clog2(DEPTH):0] LEVEL;

  always #5 CLK = ~CLK;

  burst_scheduler #(.TW(TW), .CW(CW), .NW(NW), .FW(FW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .SYS_TIME(SYS_TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE),
    .T1hz(T1hz), .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK), .TIME_NOW(TIME_NOW),
    .WR_DATA(WR_DATA), .MEM_DDS_freq(MEM_DDS_freq), .MEM_TIME_START(MEM_TIME_START),
    .MEM_N_impuls(MEM_N_impuls), .MEM_TYPE_impulse(MEM_TYPE_impulse),
    .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Interval_Tp(MEM_Interval_Tp),
    .MEM_Tblank1(MEM_Tblank1), .MEM_Tblank2(MEM_Tblank2), .ABORT(ABORT),
    .ERR_CLR(ERR_CLR), .DDS_freq(DDS_freq), .DDS_start(DDS_start), .En_Iz(En_Iz),
    .En_Pr(En_Pr), .BUSY(BUSY), .LEVEL(LEVEL), .FULL(FULL), .OVF(OVF), .LATE(LATE)
  );

  int          n_vec = 0;
  int          n_fail = 0;
  logic [63:0] exp_time = '0;

  // Burst measurement results
  int          m_dds, m_iz_rises, m_pr_rises, m_iz_hi, m_pr_hi;
  logic [63:0] t_iz_first, t_iz_last, t_pr_first, t_end;
  logic [47:0] freqs[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; the time model follows TIME_NOW outside reset.
  task automatic tick();
    logic rst_s;
    rst_s = RESET;
    @(posedge CLK);
    #1;
    if (!rst_s) exp_time = exp_time + 64'd1;
  endtask

  task automatic push(input logic [47:0] f, input logic [63:0] st, input logic [15:0] n,
                      input logic [1:0] ty, input logic [31:0] ti, input logic [31:0] tb1,
                      input logic [31:0] tp, input logic [31:0] tb2);
    MEM_DDS_freq = f; MEM_TIME_START = st; MEM_N_impuls = n; MEM_TYPE_impulse = ty;
    MEM_Interval_Ti = ti; MEM_Tblank1 = tb1; MEM_Interval_Tp = tp; MEM_Tblank2 = tb2;
    WR_DATA = 1'b1;
    tick();
    WR_DATA = 1'b0;
  endtask

  // Observe the outputs until the queue drains and the FSM is idle.
  task automatic measure(input int max_cyc);
    logic prev_iz, prev_pr;
    int   cyc;
    m_dds = 0; m_iz_rises = 0; m_pr_rises = 0; m_iz_hi = 0; m_pr_hi = 0;
    t_iz_first = '0; t_iz_last = '0; t_pr_first = '0;
    freqs.delete();
    prev_iz = 1'b0; prev_pr = 1'b0; cyc = 0;
    while ((BUSY || LEVEL != '0) && cyc < max_cyc) begin
      if (DDS_start) begin m_dds++; freqs.push_back(DDS_freq); end
      if (En_Iz) m_iz_hi++;
      if (En_Pr) m_pr_hi++;
      if (En_Iz && !prev_iz) begin
        if (m_iz_rises == 0) t_iz_first = TIME_NOW;
        t_iz_last = TIME_NOW;
        m_iz_rises++;
      end
      if (En_Pr && !prev_pr) begin
        if (m_pr_rises == 0) t_pr_first = TIME_NOW;
        m_pr_rises++;
      end
      prev_iz = En_Iz; prev_pr = En_Pr;
      tick();
      cyc++;
    end
    t_end = TIME_NOW;
    check("burst_done", {63'b0, (BUSY || LEVEL != '0)}, 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] st;
    logic [47:0] exp_f;
    int          c;

    // ---------------- reset
    tick(); tick();
    check("rst_time", TIME_NOW, 0);
    check("rst_ok", SYS_TIME_UPDATE_OK, 0);
    check("rst_freq", DDS_freq, 0);
    check("rst_gates", {DDS_start, En_Iz, En_Pr, BUSY}, 0);
    check("rst_level", LEVEL, 0);
    check("rst_flags", {FULL, OVF, LATE}, 0);
    RESET = 1'b0;
    tick();
    check("time_count", TIME_NOW, 1);

    // ---------------- preset
    SYS_TIME = 64'h1000; SYS_TIME_UPDATE = 1'b1;
    tick();
    check("ok_armed", SYS_TIME_UPDATE_OK, 0);
    T1hz = 1'b1;
    tick();
    T1hz = 1'b0;
    check("pre_edge1", TIME_NOW, exp_time);
    tick();
    exp_time = 64'h1000;
    check("preset_val", TIME_NOW, 64'h1000);
    check("preset_ok", SYS_TIME_UPDATE_OK, 1);
    tick();
    check("preset_cnt", TIME_NOW, 64'h1001);
    SYS_TIME = 64'h5000;
    T1hz = 1'b1; tick(); T1hz = 1'b0; tick(); tick();
    check("second_1pps_ignored", TIME_NOW, exp_time);
    SYS_TIME_UPDATE = 1'b0; tick();
    SYS_TIME_UPDATE = 1'b1; tick();
    check("ok_cleared", SYS_TIME_UPDATE_OK, 0);
    SYS_TIME_UPDATE = 1'b0;

    // ---------------- single burst
    push(48'h123456, 64'h12C0, 16'd1, 2'd0, 32'h1800, 32'h180, 32'h1800, 32'h180);
    check("single_level", LEVEL, 1);
    tick();
    check("single_freq", DDS_freq, 48'h123456);
    check("single_busy", BUSY, 1);
    measure(20000);
    check("single_iz_time", t_iz_first, 64'h12C1);
    check("single_iz_hi", m_iz_hi, 6144);
    check("single_pr_hi", m_pr_hi, 6144);
    check("single_pr_off", t_pr_first - t_iz_first, 6528);
    check("single_dds", m_dds, 1);
    check("single_end", t_end - t_iz_first, 13056);

    // ---------------- coherent N=3
    st = exp_time + 64'd20;
    push(48'hC0, st, 16'd3, 2'd1, 32'd10, 32'd2, 32'd10, 32'd2);
    measure(500);
    check("coh_iz_time", t_iz_first, st + 64'd1);
    check("coh_iz_rises", m_iz_rises, 3);
    check("coh_pr_rises", m_pr_rises, 3);
    check("coh_dds", m_dds, 1);
    check("coh_iz_hi", m_iz_hi, 30);
    check("coh_pr_hi", m_pr_hi, 30);
    check("coh_pr_off", t_pr_first - t_iz_first, 12);
    check("coh_period", t_iz_last - t_iz_first, 48);

    // ---------------- incoherent N=3
    st = exp_time + 64'd20;
    push(48'hD0, st, 16'd3, 2'd0, 32'd10, 32'd2, 32'd10, 32'd2);
    measure(500);
    check("inc_dds", m_dds, 3);
    check("inc_iz_rises", m_iz_rises, 3);

    // ---------------- queue fill / overflow / order
    st = exp_time + 64'd100;
    push(48'hA, st, 16'd1, 2'd0, 32'd2, 32'd1, 32'd2, 32'd1);
    tick();
    check("q_wait_busy", BUSY, 1);
    check("q_wait_level", LEVEL, 0);
    for (int i = 1; i <= 5; i++)
      push(48'hA + 48'(i), st + 64'(20 * i), 16'd1, 2'd0, 32'd2, 32'd1, 32'd2, 32'd1);
    check("q_level_full", LEVEL, 4);
    check("q_full", FULL, 1);
    check("q_ovf", OVF, 1);
    ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
    check("q_ovf_clr", OVF, 0);
    measure(1000);
    check("q_dds_count", m_dds, 5);
    for (int i = 0; i < 5; i++) begin
      exp_f = 48'hA + 48'(i);
      check($sformatf("q_order%0d", i), (freqs.size() > i) ? 64'(freqs[i]) : 64'hDEAD, 64'(exp_f));
    end
    check("q_no_late", LATE, 0);

    // ---------------- late descriptor
    push(48'hE1, exp_time - 64'd5, 16'd1, 2'd0, 32'd2, 32'd1, 32'd2, 32'd1);
    tick();
    check("late_flag", LATE, 1);
    check("late_idle", {BUSY, En_Iz, En_Pr}, 0);
    check("late_level", LEVEL, 0);
    ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
    check("late_clr", LATE, 0);

    // ---------------- N=0 descriptor
    push(48'hE2, exp_time + 64'd50, 16'd0, 2'd0, 32'd2, 32'd1, 32'd2, 32'd1);
    tick();
    check("zero_idle", BUSY, 0);
    check("zero_no_late", LATE, 0);
    check("zero_level", LEVEL, 0);

    // ---------------- Tblank1 = 0
    push(48'hE3, exp_time + 64'd10, 16'd1, 2'd0, 32'd3, 32'd0, 32'd3, 32'd1);
    measure(200);
    check("tb0_pr_off", t_pr_first - t_iz_first, 3);
    check("tb0_iz_hi", m_iz_hi, 3);
    check("tb0_pr_hi", m_pr_hi, 3);

    // ---------------- ABORT during RX
    push(48'hF0, exp_time + 64'd10, 16'd1, 2'd0, 32'd2, 32'd1, 32'd50, 32'd1);
    tick();
    push(48'hF1, exp_time + 64'd500, 16'd1, 2'd0, 32'd2, 32'd1, 32'd2, 32'd1);
    push(48'hF2, exp_time + 64'd600, 16'd1, 2'd0, 32'd2, 32'd1, 32'd2, 32'd1);
    check("ab_level", LEVEL, 2);
    c = 0;
    while (!En_Pr && c < 100) begin tick(); c++; end
    check("ab_in_rx", En_Pr, 1);
    tick(); tick(); tick();
    MEM_DDS_freq = 48'hF3; MEM_TIME_START = exp_time + 64'd700; MEM_N_impuls = 16'd1;
    ABORT = 1'b1; WR_DATA = 1'b1;
    tick();
    ABORT = 1'b0; WR_DATA = 1'b0;
    check("ab_gates", {En_Iz, En_Pr, DDS_start}, 0);
    check("ab_level0", LEVEL, 0);
    check("ab_busy", BUSY, 0);
    check("ab_ovf", OVF, 0);
    check("ab_time", TIME_NOW, exp_time);
    tick();
    check("ab_wr_dropped", LEVEL, 0);
    check("ab_still_idle", BUSY, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/burst_scheduler.md
# burst_scheduler

Parametrised, queued successor to the master-start synchroniser. It keeps the system time counter with 1PPS preset, accepts burst descriptors into a DEPTH-deep queue, and plays them back one after another. Each burst is N transmit/receive periods that drive En_Iz/En_Pr gates and DDS start pulses. It sits between the register/command interface and the dds_chirp generator in the 48 MHz domain.

## Interface
Parameters:
- TW, 64: system time / start-time width
- CW, 32: interval counter width (Ti, Tp, Tblank1, Tblank2)
- NW, 16: pulse count width
- FW, 48: DDS frequency word width
- DEPTH, 4: descriptor queue depth (power of 2, ≥2)

Ports:
- CLK  in  1  system clock (48 MHz). One clock; reset is asynchronous and active-high.
- RESET  in  1  asynchronous active-high reset
- SYS_TIME  in  TW  preset value loaded on T1hz
- SYS_TIME_UPDATE  in  1  level; arms preset
- T1hz  in  1  second mark (synchronous to CLK, any width)
- SYS_TIME_UPDATE_OK  out  1  preset has occurred since last arm
- TIME_NOW  out  TW  system time
- WR_DATA  in  1  push descriptor (1-cycle strobe)
- MEM_DDS_freq  in  FW  descriptor: DDS frequency
- MEM_TIME_START  in  TW  descriptor: burst start time
- MEM_N_impuls  in  NW  descriptor: periods in burst
- MEM_TYPE_impulse  in  2  descriptor: 0 incoherent, 1 coherent, 2/3 treated as 0
- MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2  in  CW each  phase lengths in CLK cycles
- ABORT  in  1  flush queue, stop burst
- ERR_CLR  in  1  clears sticky errors
- DDS_freq  out  FW  frequency of active burst
- DDS_start  out  1  one-cycle DDS (re)start strobe
- En_Iz  out  1  transmit gate
- En_Pr  out  1  receive gate
- BUSY  out  1  burst in WAIT or playback
- LEVEL  out  $clog2(DEPTH)+1  queued descriptors
- FULL  out  1  LEVEL == DEPTH
- OVF  out  1  sticky: write dropped
- LATE  out  1  sticky: descriptor discarded as late

## Operation
- Time: TIME_NOW increments by 1 every cycle and wraps modulo 2^TW. A rising edge of T1hz (registered edge detect) while SYS_TIME_UPDATE=1 and OK=0 loads TIME_NOW<=SYS_TIME and sets OK. OK clears on a rising edge of SYS_TIME_UPDATE.
- Queue: WR_DATA with FULL=0 pushes all MEM_* fields. WR_DATA with FULL=1 is dropped and sets OVF. FULL is taken from the registered count, so a same-cycle pop does not admit the write.
- FSM states: IDLE, WAIT, TX, BL1, RX, BL2.
- IDLE: if LEVEL>0, pop the head. If N=0, discard it and stay IDLE. If TIME_START<TIME_NOW, discard it, set LATE and stay IDLE. Otherwise latch the descriptor, load DDS_freq and go to WAIT.
- WAIT: when TIME_NOW>=TIME_START, go to TX with pulse counter = 1. A forward preset jump therefore starts the burst immediately.
- TX (En_Iz=1) for Ti cycles → BL1 for Tblank1 → RX (En_Pr=1) for Tp → BL2 for Tblank2.
- At the end of BL2: if counter<N, increment the counter and go to TX; else go to IDLE.
- Any phase of length 0 is skipped in zero cycles.
- DDS_start: type 0 pulses on entry to every TX; type 1 pulses only on the first TX of the burst.
- ABORT (highest priority): flushes the queue (LEVEL=0), FSM to IDLE, En_Iz/En_Pr/DDS_start low next cycle. A WR_DATA in the same cycle is dropped without setting OVF. TIME_NOW is unaffected.
- ERR_CLR clears OVF/LATE. An error set in the same cycle wins.
- Comparisons are unsigned TW-bit. Phase counters are CW-bit down-counters; the pulse counter is NW-bit.

## Timing
- Reset values: TIME_NOW=0, OK=0, DDS_freq=0, DDS_start=0, En_Iz=0, En_Pr=0, BUSY=0, LEVEL=0, FULL=0, OVF=0, LATE=0, FSM=IDLE, queue empty. Reset mid-burst drops the gates asynchronously.
- Push: LEVEL updates on the edge after WR_DATA. Pop occurs in the first IDLE cycle with LEVEL>0. DDS_freq is valid from the edge after the pop, so from the second edge after WR_DATA at the earliest.
- Start: En_Iz and DDS_start go high on the edge following the cycle where TIME_NOW==TIME_START (observed with TIME_NOW==TIME_START+1).
- Each phase holds exactly its programmed cycle count. En_Pr rises exactly Ti+Tblank1 cycles after En_Iz rises. The period is Ti+Tblank1+Tp+Tblank2.
- Back-to-back: the next descriptor is popped in the IDLE cycle after the final BL2. A following burst therefore cannot start before 2 cycles after the previous end.
- BUSY is high from the edge after the pop until FSM returns to IDLE.
- Preset: TIME_NOW==SYS_TIME on the edge after the T1hz rising edge is registered (2 cycles after T1hz rises), and counts on from there.

## Test plan
- Preset: arm with SYS_TIME=0x1000, pulse T1hz → TIME_NOW=0x1000 two cycles after T1hz rises, OK=1. A second T1hz is ignored until SYS_TIME_UPDATE re-rises.
- Single burst: START=0x12C0, N=1, Ti=Tp=0x1800, Tb1=Tb2=0x180, type 0 → En_Iz high 6144 cycles from TIME_NOW=0x12C1, En_Pr high 6144 cycles starting 6528 cycles later, one DDS_start.
- Coherent N=3, Ti=Tp=10, Tb=2 → three En_Iz/En_Pr pairs with period 24 cycles, DDS_start only once. Type 0 with the same values gives 3 DDS_start pulses.
- Queue: 5 writes with DEPTH=4 while the FSM is blocked in WAIT → LEVEL=4, FULL=1, OVF=1. Bursts then play in write order. ERR_CLR clears OVF.
- Late/zero: START below TIME_NOW → discarded, LATE=1, no gates. N=0 → discarded, no LATE. Tblank1=0 → En_Pr rises on the cycle after En_Iz falls.
- ABORT during RX with 2 queued → gates low next cycle, LEVEL=0, BUSY=0. Simultaneous WR_DATA is dropped and OVF stays 0.
